mask_encoder_32to5: RTL and testbench
=====================================

# mask_encoder_32to5

Sequential 32-to-5 bit-mask encoder: the inverse of the team's 5-to-32 one-hot shift decoder. It accepts a 32-bit mask over a valid/ready handshake and emits the 5-bit index of every set bit, one per handshaked beat, lowest index first. Each beat carries a beat sequence number and a last flag. It sits between mask producers (pending-interrupt vectors, register-bitmap scans, load/store-multiple masks) and index-driven consumers.

## Interface
- No parameters; width fixed at 32 in / 5 out.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_mask is valid.
- in_ready  output  1  block can accept a mask.
- in_mask  input  32  mask to encode.
- out_valid  output  1  out_idx/out_seq/out_last/out_none are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_idx  output  5  index of the current set bit.
- out_seq  output  5  beat number within the current mask, starting at 0.
- out_last  output  1  current beat is the final beat for this mask.
- out_none  output  1  the loaded mask was all-zero; this is a single dummy beat.

## Operation
- State: `state` (IDLE/EMIT), `pend[31:0]` (bits not yet emitted), `seq[4:0]`, `none` flag.
- IDLE: in_ready=1, out_valid=0. When in_valid is high: pend<=in_mask, seq<=0, none<=(in_mask==0), state<=EMIT.
- EMIT: out_valid=1.
  - out_idx = lowest set bit of pend.
  - out_seq = seq.
  - out_last = (pend has ≤1 bit set).
  - out_none = none.
- Beat handshake (out_valid&out_ready): clear bit out_idx in pend, seq<=seq+1.
  - If out_last: state<=IDLE, unless a new load occurs in the same cycle.
- in_ready = (state==IDLE) | (state==EMIT & out_ready & out_last).
  - This allows back-to-back masks: a load in the last-beat cycle reinitialises pend/seq/none and stays in EMIT.
- Zero mask: exactly one beat, with out_idx=0, out_seq=0, out_last=1, out_none=1.
- out_valid holds, and out_idx/out_seq/out_last/out_none stay stable, while out_ready is low.
- in_mask is sampled only on an in_valid&in_ready cycle; changes at other times are ignored.
- seq never wraps: at most 32 beats, so its maximum is 31.
- In IDLE, out_idx, out_seq, out_last and out_none drive 0.

## Timing
- Reset (async, rst_n low): state=IDLE, pend=0, seq=0, none=0.
  - Outputs during reset: in_ready=1, out_valid=0, out_idx=0, out_seq=0, out_last=0, out_none=0.
- Reset asserted mid-mask abandons the remaining beats immediately. There are no spurious beats after release.
- Latency: mask accepted at edge N gives first out_valid at edge N+1, after registered state.
- Throughput: one index per cycle with out_ready held high.
  - A mask with k bits set (k≥1) occupies k cycles of EMIT.
  - Back-to-back masks incur zero bubble cycles.
- in_ready is combinational from out_ready and state. out_valid, out_idx, out_seq, out_last and out_none depend on registers only.

## Configuration
- MASK_ENC_MSB_FIRST_EN defined: emit set bits highest index first.
  - out_idx = highest set bit of pend.
  - out_last, out_seq and zero-mask behaviour are unchanged.
  - The zero-mask dummy beat still reports out_idx=0.
- MASK_ENC_MSB_FIRST_EN undefined (default): lowest index first, as specified above.

## Test plan
- Reset then load 32'h8000_0011, out_ready=1 → beats idx 0,4,31; seq 0,1,2; out_last only on idx 31; first beat 1 cycle after accept.
- Load 32'h0000_0000 → single beat: idx=0, seq=0, last=1, none=1; in_ready=1 in that beat's cycle.
- Load 32'hFFFF_FFFF with out_ready toggling 1/0 → idx 0..31 in order, no beat lost or duplicated, outputs stable while stalled, final beat seq=31, last=1.
- Second mask 32'h0000_0006 presented with in_valid during the last beat of 32'h0000_0001 → idx 0 (last), then idx 1, 2 on the next cycles with seq restarting at 0, no idle cycle.
- Assert rst_n low after 2 beats of 32'h0000_00FF → out_valid=0 and in_ready=1 immediately; after release no residual beats; new mask 32'h0000_0100 → idx 8.
- With MASK_ENC_MSB_FIRST_EN, load 32'h8000_0011 → idx 31,4,0; last on idx 0.

Source files
------------

// File: rtl/mask_encoder_32to5_if.sv
// Handshake bundle for the 32-to-5 mask encoder: mask input channel and index output channel.
// master: mask producer / index consumer side (drives in_valid, in_mask, out_ready).
// slave : encoder side (drives in_ready and the out_* beat fields).
interface mask_encoder_32to5_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_mask;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [4:0]  out_seq;
  logic        out_last;
  logic        out_none;

  modport master (
    output in_valid, in_mask, out_ready,
    input  in_ready, out_valid, out_idx, out_seq, out_last, out_none
  );

  modport slave (
    input  in_valid, in_mask, out_ready,
    output in_ready, out_valid, out_idx, out_seq, out_last, out_none
  );
endinterface

// File: rtl/mask_encoder_32to5.sv
// Sequential 32-to-5 mask encoder: emits the index of every set bit of a mask, one per beat.
// Latency: mask accepted at edge N, first beat valid after edge N+1; one beat/cycle, no bubble between masks.
// Backpressure: out_ready low holds the current beat stable; in_ready only rises on the final beat or in IDLE.
//
// Ports: clk, rst_n (async active-low), bus (slave modport): in_valid/in_ready/in_mask,
//        out_valid/out_ready/out_idx/out_seq/out_last/out_none.
// Option: define MASK_ENC_MSB_FIRST_EN to emit set bits highest index first (default lowest first).
module mask_encoder_32to5 (
  input  logic                 clk,
  input  logic                 rst_n,
  mask_encoder_32to5_if.slave  bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state;
  logic [31:0] pend;    // bits of the current mask not yet emitted
  logic [4:0]  seq;
  logic        none;

  logic [4:0]  pick;
  logic        single;
  logic        emit;
  logic        load;
  logic        beat;

  // Priority pick over the pending bits; the last match in loop order wins.
  always_comb begin
    pick = '0;
`ifdef MASK_ENC_MSB_FIRST_EN
    for (int i = 0; i < 32; i++) begin
      if (pend[i]) pick = 5'(i);
    end
`else
    for (int i = 31; i >= 0; i--) begin
      if (pend[i]) pick = 5'(i);
    end
`endif
  end

  // At most one pending bit left: this beat is the last one (also true for the zero-mask dummy beat).
  assign single = ((pend & (pend - 32'd1)) == 32'd0);
  assign emit   = (state == EMIT);

  assign bus.out_valid = emit;
  assign bus.out_idx   = emit ? pick : 5'd0;
  assign bus.out_seq   = emit ? seq  : 5'd0;
  assign bus.out_last  = emit & single;
  assign bus.out_none  = emit & none;

  // Accepting during the final beat lets the next mask follow with no idle cycle.
  assign bus.in_ready  = ~emit | (bus.out_ready & single);

  assign load = bus.in_valid & bus.in_ready;
  assign beat = emit & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= '0;
      seq   <= '0;
      none  <= 1'b0;
    end else if (load) begin
      state <= EMIT;
      pend  <= bus.in_mask;
      seq   <= '0;
      none  <= (bus.in_mask == 32'd0);
    end else if (beat) begin
      pend <= pend & ~(32'd1 << pick);
      if (single) begin
        // Final beat: park in IDLE with counters cleared, so seq never wraps past 31.
        state <= IDLE;
        seq   <= '0;
        none  <= 1'b0;
      end else begin
        seq <= seq + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_mask_encoder_32to5.sv
module tb_mask_encoder_32to5;

  logic clk = 1'b0;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;

`ifdef MASK_ENC_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  mask_encoder_32to5_if bus();

  mask_encoder_32to5 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle; all sampling happens 1 time unit after the edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int ord(input int lsb_idx, input int msb_idx);
    return MSB ? msb_idx : lsb_idx;
  endfunction

  task automatic beat_chk(input string tag, input int idx, input int seq,
                          input bit last, input bit none);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_idx"},   32'(bus.out_idx),   32'(idx));
    chk({tag, "_seq"},   32'(bus.out_seq),   32'(seq));
    chk({tag, "_last"},  32'(bus.out_last),  32'(last));
    chk({tag, "_none"},  32'(bus.out_none),  32'(none));
  endtask

  initial begin
    // ---- reset state
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mask   = 32'd0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_idx",       32'(bus.out_idx),   32'd0);
    chk("rst_seq",       32'(bus.out_seq),   32'd0);
    chk("rst_last",      32'(bus.out_last),  32'd0);
    chk("rst_none",      32'(bus.out_none),  32'd0);
    step;
    step;
    rst_n = 1'b1;
    step;

    // ---- 8000_0011, out_ready high; in_mask changes after accept are ignored
    bus.in_valid  = 1'b1;
    bus.in_mask   = 32'h8000_0011;
    bus.out_ready = 1'b1;
    #1;
    chk("t1_pre_valid", 32'(bus.out_valid), 32'd0);
    step;
    bus.in_valid = 1'b0;
    bus.in_mask  = 32'hFFFF_FFFF;
    beat_chk("t1_b0", ord(0, 31), 0, 1'b0, 1'b0);
    chk("t1_b0_in_ready", 32'(bus.in_ready), 32'd0);
    step;
    beat_chk("t1_b1", 4, 1, 1'b0, 1'b0);
    step;
    beat_chk("t1_b2", ord(31, 0), 2, 1'b1, 1'b0);
    step;
    chk("t1_end_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_end_ready", 32'(bus.in_ready),  32'd1);

    // ---- zero mask: single dummy beat
    bus.in_valid = 1'b1;
    bus.in_mask  = 32'h0000_0000;
    step;
    bus.in_valid = 1'b0;
    beat_chk("t2_b0", 0, 0, 1'b1, 1'b1);
    chk("t2_in_ready", 32'(bus.in_ready), 32'd1);
    step;
    chk("t2_end_valid", 32'(bus.out_valid), 32'd0);

    // ---- FFFF_FFFF with out_ready toggling: each beat stalls one cycle then completes
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mask   = 32'hFFFF_FFFF;
    step;
    bus.in_valid = 1'b0;
    bus.in_mask  = 32'd0;
    for (int i = 0; i < 32; i++) begin
      bus.out_ready = 1'b0;
      #1;
      chk($sformatf("t3_idx_%0d", i), 32'(bus.out_idx), 32'(ord(i, 31 - i)));
      chk($sformatf("t3_seq_%0d", i), 32'(bus.out_seq), 32'(i));
      step;
      chk($sformatf("t3_hold_valid_%0d", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("t3_hold_idx_%0d", i),   32'(bus.out_idx),   32'(ord(i, 31 - i)));
      chk($sformatf("t3_hold_seq_%0d", i),   32'(bus.out_seq),   32'(i));
      chk($sformatf("t3_hold_last_%0d", i),  32'(bus.out_last),  32'(i == 31));
      bus.out_ready = 1'b1;
      step;
    end
    chk("t3_end_valid", 32'(bus.out_valid), 32'd0);

    // ---- back-to-back: 0000_0006 offered during the last beat of 0000_0001
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_mask   = 32'h0000_0001;
    step;
    bus.in_mask = 32'h0000_0006;
    #1;
    beat_chk("t4_a0", 0, 0, 1'b1, 1'b0);
    chk("t4_a0_in_ready", 32'(bus.in_ready), 32'd1);
    step;
    bus.in_valid = 1'b0;
    beat_chk("t4_b0", ord(1, 2), 0, 1'b0, 1'b0);
    step;
    beat_chk("t4_b1", ord(2, 1), 1, 1'b1, 1'b0);
    step;
    chk("t4_end_valid", 32'(bus.out_valid), 32'd0);

    // ---- reset mid-mask after 2 beats of 0000_00FF
    bus.in_valid = 1'b1;
    bus.in_mask  = 32'h0000_00FF;
    step;
    bus.in_valid = 1'b0;
    beat_chk("t5_b0", ord(0, 7), 0, 1'b0, 1'b0);
    step;
    beat_chk("t5_b1", ord(1, 6), 1, 1'b0, 1'b0);
    step;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_ready", 32'(bus.in_ready),  32'd1);
    chk("t5_rst_idx",   32'(bus.out_idx),   32'd0);
    step;
    rst_n = 1'b1;
    step;
    chk("t5_post_valid0", 32'(bus.out_valid), 32'd0);
    step;
    chk("t5_post_valid1", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_mask  = 32'h0000_0100;
    step;
    bus.in_valid = 1'b0;
    beat_chk("t5_new", 8, 0, 1'b1, 1'b0);
    step;
    chk("t5_end_valid", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
